// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle between the CPU datapath and the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            kill;
    logic            in_ready;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            rd_write_enable;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd_in, kill,
        input  in_ready, busy, result_valid, result, rd_out, rd_write_enable
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_in, kill,
        output in_ready, busy, result_valid, result, rd_out, rd_write_enable
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 33-cycle latency.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle array product (2-cycle latency).
module muldiv_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam int unsigned CntW = $clog2(ITER) + 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            neg_q;
    logic            sign_a_q;
    logic            div0_q;

    logic            valid_q;
    logic            we_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_out_q;

    logic            accept;
    logic            commit;
    logic            calc_last;
    logic            req_div;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_val;

    // Request decode: which operands are interpreted as signed.
    always_comb begin
        req_div = bus.funct3[2];
        sign_a  = 1'b0;
        sign_b  = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin
                sign_a = bus.rs1_val[XLEN-1];
                sign_b = bus.rs2_val[XLEN-1];
            end
            3'b010:  sign_a = bus.rs1_val[XLEN-1];
            default: ;
        endcase
        a_mag = sign_a ? (~bus.rs1_val + 1'b1) : bus.rs1_val;
        b_mag = sign_b ? (~bus.rs2_val + 1'b1) : bus.rs2_val;
    end

    assign accept = (state_q == StIdle) && bus.start && !bus.kill;
    assign commit = (state_q == StDone) && !bus.kill;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, opnd_q} * {{XLEN{1'b0}}, lo_q};
    assign calc_last = !op_q[2] || (cnt_q == CntW'(ITER - 1));
`else
    assign calc_last = (cnt_q == CntW'(ITER - 1));
`endif

    // One radix-2 step. Multiply: {hi,lo} holds partial product over the multiplier bits.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN + 1){1'b0}});
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift[XLEN-1:0] - opnd_q;
        if (op_q[2]) begin
            step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
`ifdef MULDIV_FAST_MUL_EN
        if (!op_q[2]) begin
            step_hi = fast_prod[2*XLEN-1:XLEN];
            step_lo = fast_prod[XLEN-1:0];
        end
`endif
    end

    // Sign fix-up and result selection from the magnitude datapath.
    always_comb begin
        prod_s = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quo_s  = div0_q ? {XLEN{1'b1}} : (neg_q ? (~lo_q + 1'b1) : lo_q);
        rem_s  = sign_a_q ? (~hi_q + 1'b1) : hi_q;
        case (op_q)
            3'b000:                 final_val = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = quo_s;
            default:                final_val = rem_s;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = StCalc;
            StCalc: begin
                if (bus.kill) begin
                    state_d = StIdle;
                end else if (calc_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready        = (state_q == StIdle);
        bus.busy            = (state_q == StCalc) || (state_q == StDone);
        bus.result_valid    = valid_q;
        bus.rd_write_enable = we_q;
        bus.result          = result_q;
        bus.rd_out          = rd_out_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            div0_q   <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            op_q     <= bus.funct3;
            rd_q     <= bus.rd_in;
            hi_q     <= '0;
            lo_q     <= req_div ? a_mag : b_mag;
            opnd_q   <= req_div ? b_mag : a_mag;
            neg_q    <= sign_a ^ sign_b;
            sign_a_q <= sign_a;
            div0_q   <= (bus.rs2_val == '0);
        end else if (state_q == StCalc) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= step_hi;
            lo_q  <= step_lo;
        end
    end

    // Write-back is registered out of DONE so a kill in DONE can still suppress it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            valid_q <= commit;
            we_q    <= commit && (rd_q != 5'd0);
            if (commit) begin
                result_q <= final_val;
                rd_out_q <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, hazard sequences and randomized ops.
module tb_muldiv_unit;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    muldiv_unit_if bus ();

    muldiv_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] f3);
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 2;
`endif
        return 33;
    endfunction

    // Reference model from the RV32M definitions using wide integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.funct3  = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // lat = k means result_valid was seen in the cycle after edge E+k.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output logic we, output int lat);
        issue(f3, a, b, rd);
        lat = 0;
        while (!bus.result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        rdo = bus.rd_out;
        we  = bus.rd_write_enable;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    vec_t        vecs[10];
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        we;
    int          lat;
    int          pulses;
    int          wes;

    initial begin
        n_pass      = 0;
        n_total     = 0;
        bus.start   = 1'b0;
        bus.funct3  = 3'd0;
        bus.rs1_val = 32'd0;
        bus.rs2_val = 32'd0;
        bus.rd_in   = 5'd0;
        bus.kill    = 1'b0;
        reset       = 1'b1;

        vecs[0] = '{"div_neg",     3'b100, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD};
        vecs[1] = '{"rem_neg",     3'b110, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF};
        vecs[2] = '{"divu_zero",   3'b101, 32'h0000_1234, 32'd0,         5'd9,  32'hFFFF_FFFF};
        vecs[3] = '{"remu_zero",   3'b111, 32'h0000_1234, 32'd0,         5'd9,  32'h0000_1234};
        vecs[4] = '{"div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'h8000_0000};
        vecs[5] = '{"rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
        vecs[6] = '{"mulh_m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
        vecs[7] = '{"mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE};
        vecs[8] = '{"mul_7x6",     3'b000, 32'd7,         32'd6,         5'd31, 32'd42};
        vecs[9] = '{"mulhsu_neg",  3'b010, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_valid", {31'd0, bus.result_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, we, lat);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(exp_lat(vecs[i].f3)));
            check({vecs[i].name, "_rd"}, {27'd0, rdo}, {27'd0, vecs[i].rd});
            check({vecs[i].name, "_we"}, {31'd0, we}, 32'd1);
            @(negedge clk);
            check({vecs[i].name, "_pulse"}, {31'd0, bus.result_valid}, 32'd0);
        end

        // rd_in = 0: result is produced but never written back.
        run_op(3'b101, 32'd100, 32'd7, 5'd0, res, rdo, we, lat);
        check("rd0_result", res, 32'd14);
        check("rd0_lat", 32'(lat), 32'd33);
        check("rd0_we", {31'd0, we}, 32'd0);

        // kill in IDLE blocks a simultaneous start.
        @(negedge clk);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check("idle_kill_ready", {31'd0, bus.in_ready}, 32'd1);
        check("idle_kill_busy", {31'd0, bus.busy}, 32'd0);

        // start while busy is ignored: one result, from the first request.
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            if (k == 5) begin
                bus.start   = 1'b1;
                bus.funct3  = 3'b000;
                bus.rs1_val = 32'd9;
                bus.rs2_val = 32'd9;
                bus.rd_in   = 5'd17;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.result_valid) begin
                pulses++;
                check("busy_start_result", bus.result, 32'd14);
                check("busy_start_rd", {27'd0, bus.rd_out}, 32'd3);
                check("busy_start_lat", 32'(k), 32'd33);
            end
            @(negedge clk);
        end
        check("busy_start_pulses", 32'(pulses), 32'd1);

        // kill at CALC cycle 10.
        issue(3'b100, 32'hFFFF_FF00, 32'd3, 5'd8);
        repeat (10) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_calc_ready", {31'd0, bus.in_ready}, 32'd1);
        pulses = 0;
        wes    = 0;
        repeat (50) begin
            if (bus.result_valid) pulses++;
            if (bus.rd_write_enable) wes++;
            @(negedge clk);
        end
        check("kill_calc_pulses", 32'(pulses + wes), 32'd0);

        // kill during the DONE cycle.
        issue(3'b101, 32'd50, 32'd5, 5'd12);
        repeat (exp_lat(3'b101) - 1) @(negedge clk);
        check("kill_done_busy", {31'd0, bus.busy}, 32'd1);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        pulses = 0;
        repeat (40) begin
            if (bus.result_valid || bus.rd_write_enable) pulses++;
            @(negedge clk);
        end
        check("kill_done_pulses", 32'(pulses), 32'd0);
        check("kill_done_ready", {31'd0, bus.in_ready}, 32'd1);

        // reset at CALC cycle 15, after a non-zero result is on the outputs.
        run_op(3'b000, 32'd7, 32'd6, 5'd9, res, rdo, we, lat);
        issue(3'b100, 32'd1000, 32'd7, 5'd7);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (50) begin
            if (bus.result_valid || bus.rd_write_enable) pulses++;
            @(negedge clk);
        end
        check("mid_rst_pulses", 32'(pulses), 32'd0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 48; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            f3 = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            rd = 5'($urandom_range(0, 31));
            run_op(f3, a, b, rd, res, rdo, we, lat);
            check($sformatf("rand%0d_f%0d_%h_%h", n, f3, a, b), res, ref_model(f3, a, b));
            check($sformatf("rand%0d_lat", n), 32'(lat), 32'(exp_lat(f3)));
            check($sformatf("rand%0d_we", n), {31'd0, we}, {31'd0, rd != 5'd0});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
